// File: rtl/sfu_ofifo_drain.sv
// Drains NUM_WORDS show-ahead entries from COL parallel ofifo tiles into packed
// SRAM words, with optional per-lane ReLU and a one-cycle registered output stage.
module sfu_ofifo_drain #(
  parameter int COL       = 8,
  parameter int DW        = 16,
  parameter int NUM_WORDS = 16,
  parameter int AW        = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              relu_en,
  input  logic [AW-1:0]     base_addr,
  input  logic [COL-1:0]    fifo_empty,
  input  logic [COL*DW-1:0] fifo_data,
  output logic              fifo_rd,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [COL*DW-1:0] out_data,
  output logic [AW-1:0]     out_addr,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(NUM_WORDS) + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic                relu_q;
  logic [AW-1:0]       base_q;
  logic                out_valid_q;
  logic [COL*DW-1:0]   out_data_q;
  logic [AW-1:0]       out_addr_q;
  logic                done_q;
  logic                last_rd;

  // Lanes are two's-complement; a set MSB marks a negative value to clamp.
  function automatic logic [COL*DW-1:0] relu_word(input logic [COL*DW-1:0] w,
                                                  input logic en);
    relu_word = w;
    for (int i = 0; i < COL; i++) begin
      if (en && w[i*DW + DW - 1]) relu_word[i*DW +: DW] = '0;
    end
  endfunction

  assign fifo_rd = (state_q == DRAIN) && (fifo_empty == '0) && out_ready;
  assign last_rd = fifo_rd && (cnt_q == CW'(NUM_WORDS - 1));
  assign busy    = (state_q != IDLE);

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign done      = done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      relu_q      <= 1'b0;
      base_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      out_valid_q <= fifo_rd;
      done_q      <= 1'b0;
      if (fifo_rd) begin
        out_data_q <= relu_word(fifo_data, relu_q);
        out_addr_q <= base_q + AW'(cnt_q);
        cnt_q      <= cnt_q + CW'(1);
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= DRAIN;
            relu_q  <= relu_en;
            base_q  <= base_addr;
            cnt_q   <= '0;
          end
        end
        DRAIN: begin
          if (last_rd) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
